stats_counter_accum: RTL

Receive-side statistics accumulator: consumes the increment stream (tdata = increment, tid = counter index) emitted by stats collectors such as the DMA-interface statistics block and adds each increment into a wide per-index counter held in block RAM. A single-outstanding-style read port lets the register interface fetch a counter and optionally clear it atomically. Sits between the stats collectors (or their arbiter) and the control-register block.

---
 rtl/stats_counter_accum_if.sv | 30 +++
 rtl/stats_counter_accum.sv | 118 +++++++++++
 2 files changed

// File: rtl/stats_counter_accum_if.sv
// Increment stream plus counter read/clear port of the stats accumulator.
// master = stats source/register block side, slave = accumulator side.
interface stats_counter_accum_if #(
    parameter int STAT_INC_WIDTH   = 24,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64
);
    logic [STAT_INC_WIDTH-1:0]   s_axis_stat_tdata;
    logic [STAT_ID_WIDTH-1:0]    s_axis_stat_tid;
    logic                        s_axis_stat_tvalid;
    logic                        s_axis_stat_tready;
    logic [STAT_ID_WIDTH-1:0]    rd_addr;
    logic                        rd_clear;
    logic                        rd_valid;
    logic                        rd_ready;
    logic [STAT_COUNT_WIDTH-1:0] rd_data;
    logic                        rd_data_valid;

    modport master (
        output s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid,
        output rd_addr, rd_clear, rd_valid,
        input  s_axis_stat_tready, rd_ready, rd_data, rd_data_valid
    );

    modport slave (
        input  s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid,
        input  rd_addr, rd_clear, rd_valid,
        output s_axis_stat_tready, rd_ready, rd_data, rd_data_valid
    );
endinterface

// File: rtl/stats_counter_accum.sv
// Per-index RAM counter accumulator with atomic read/clear; read result 2 cycles after accept.
// Reads win over increments each cycle; both ports stalled while RAM is zeroed after reset.
module stats_counter_accum #(
    parameter int STAT_INC_WIDTH   = 24,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    stats_counter_accum_if.slave  s_if
);
    localparam int N = 2 ** STAT_ID_WIDTH;
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef logic [STAT_COUNT_WIDTH-1:0] cnt_t;

    logic [0:0]               r_state;
    logic [STAT_ID_WIDTH-1:0] r_init_addr;
    cnt_t                     r_mem [N];
    cnt_t                     r_ram_q;

    logic                      r_s1_vld;
    logic                      r_s1_rd;
    logic                      r_s1_clr;
    logic [STAT_ID_WIDTH-1:0]  r_s1_addr;
    logic [STAT_INC_WIDTH-1:0] r_s1_inc;

    logic                     r_wb_vld;
    logic [STAT_ID_WIDTH-1:0] r_wb_addr;
    cnt_t                     r_wb_dat;

    cnt_t r_rd_data;
    logic r_rd_data_valid;

    logic                     w_run;
    logic                     w_rd_acc;
    logic                     w_inc_acc;
    logic [STAT_ID_WIDTH-1:0] w_acc_addr;
    logic                     w_fwd;
    cnt_t                     w_cur;
    cnt_t                     w_new;

    assign w_run      = (r_state == S_RUN);
    assign w_rd_acc   = w_run && s_if.rd_valid;
    assign w_inc_acc  = w_run && !s_if.rd_valid && s_if.s_axis_stat_tvalid;
    assign w_acc_addr = w_rd_acc ? s_if.rd_addr : s_if.s_axis_stat_tid;

    // The RAM read for an op issued right behind a write to the same index
    // returns stale data; take the value written last cycle instead.
    assign w_fwd = r_wb_vld && (r_wb_addr == r_s1_addr);
    assign w_cur = w_fwd ? r_wb_dat : r_ram_q;

    always_comb begin
        w_new = w_cur;
        if (r_s1_rd) begin
            if (r_s1_clr) begin
                w_new = '0;
            end
        end else begin
            w_new = w_cur + cnt_t'(r_s1_inc);
        end
    end

    // Every op writes back (a non-clearing read rewrites the same value),
    // which keeps the forwarding register a plain copy of the last write.
    always_ff @(posedge clk) begin
        r_ram_q <= r_mem[w_acc_addr];
        if (!w_run) begin
            r_mem[r_init_addr] <= '0;
        end else if (r_s1_vld) begin
            r_mem[r_s1_addr] <= w_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_INIT;
            r_init_addr     <= '0;
            r_s1_vld        <= 1'b0;
            r_s1_rd         <= 1'b0;
            r_s1_clr        <= 1'b0;
            r_s1_addr       <= '0;
            r_s1_inc        <= '0;
            r_wb_vld        <= 1'b0;
            r_wb_addr       <= '0;
            r_wb_dat        <= '0;
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
        end else begin
            if (!w_run) begin
                r_init_addr <= r_init_addr + 1'b1;
                if (&r_init_addr) begin
                    r_state <= S_RUN;
                end
            end
            r_s1_vld  <= w_rd_acc || w_inc_acc;
            r_s1_rd   <= w_rd_acc;
            r_s1_clr  <= s_if.rd_clear;
            r_s1_addr <= w_acc_addr;
            r_s1_inc  <= s_if.s_axis_stat_tdata;

            r_wb_vld  <= r_s1_vld;
            r_wb_addr <= r_s1_addr;
            r_wb_dat  <= w_new;

            r_rd_data_valid <= r_s1_vld && r_s1_rd;
            if (r_s1_vld && r_s1_rd) begin
                r_rd_data <= w_cur;
            end
        end
    end

    assign s_if.rd_ready           = w_run;
    assign s_if.s_axis_stat_tready = w_run && !s_if.rd_valid;
    assign s_if.rd_data            = r_rd_data;
    assign s_if.rd_data_valid      = r_rd_data_valid;
endmodule
